// File: rtl/robs_datapath.sv
// ============================================================================
// Module      : robs_datapath
// Description : Signed shift-add multiplier datapath driven by a one-hot-ish
//               micro-operation control word; exposes status flags to a sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module robs_datapath #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [14:0]      c,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             zq,
    output logic             zy,
    output logic             zr,
    output logic [2*N-1:0]   product,
    output logic             valid
);

    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Control decode
    logic w_ldy, w_ldq, w_clra, w_ldcnt, w_dec, w_add, w_sub, w_shr;
    logic w_ldp, w_clrp, w_setv, w_clrv;
    logic unused_ctrl;

    assign w_ldy       = c[0];
    assign w_ldq       = c[1];
    assign w_clra      = c[2];
    assign w_ldcnt     = c[3];
    assign w_dec       = c[4];
    assign w_add       = c[5];
    assign w_sub       = c[6];
    assign w_shr       = c[7];
    assign w_ldp       = c[8];
    assign w_clrp      = c[9];
    assign w_setv      = c[10];
    assign w_clrv      = c[11];
    assign unused_ctrl = ^c[14:12];

    // State registers; fa_q holds the signed accumulator {F,A}
    logic [N-1:0]   y_q,   y_d;
    logic [N-1:0]   q_q,   q_d;
    logic [N:0]     fa_q,  fa_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] p_q,   p_d;
    logic           v_q,   v_d;

    logic [N:0]     w_yext;
    logic [N:0]     w_sum;

    assign w_yext = {y_q[N-1], y_q};

    always_comb begin
        w_sum = fa_q;
        if (w_add && !w_sub) begin
            w_sum = fa_q + w_yext;
        end else if (w_sub && !w_add) begin
            w_sum = fa_q - w_yext;
        end
    end

    always_comb begin
        y_d   = y_q;
        q_d   = q_q;
        fa_d  = w_sum;
        cnt_d = cnt_q;
        p_d   = p_q;
        v_d   = v_q;

        if (w_ldy) begin
            y_d = multiplicand;
        end

        if (w_clra) begin
            fa_d = '0;
        end else if (w_shr) begin
            fa_d = {w_sum[N], w_sum[N:1]};
        end

        // A clear during a shift still shifts Q, but the bit entering Q is zero
        if (w_ldq) begin
            q_d = multiplier;
        end else if (w_shr) begin
            q_d = {(w_sum[0] & ~w_clra), q_q[N-1:1]};
        end

        if (w_ldcnt) begin
            cnt_d = CNT_INIT;
        end else if (w_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        if (w_clrp) begin
            p_d = '0;
        end else if (w_ldp) begin
            p_d = {fa_q[N-1:0], q_q};
        end

        if (w_clrv) begin
            v_d = 1'b0;
        end else if (w_setv) begin
            v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q   <= '0;
            q_q   <= '0;
            fa_q  <= '0;
            cnt_q <= '0;
            p_q   <= '0;
            v_q   <= 1'b0;
        end else begin
            y_q   <= y_d;
            q_q   <= q_d;
            fa_q  <= fa_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
            v_q   <= v_d;
        end
    end

    assign zq      = q_q[0];
    assign zy      = (y_q == '0);
    assign zr      = (cnt_q == '0);
    assign product = p_q;
    assign valid   = v_q;

endmodule

`default_nettype wire

// File: tb/tb_robs_datapath.sv
// ============================================================================
// Module      : tb_robs_datapath
// Description : Self-checking bench for robs_datapath (N=8) against integer
//               multiplication and flag rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_robs_datapath;

    localparam int N = 8;

    localparam logic [14:0] LDY   = 15'h0001;
    localparam logic [14:0] LDQ   = 15'h0002;
    localparam logic [14:0] CLRA  = 15'h0004;
    localparam logic [14:0] LDCNT = 15'h0008;
    localparam logic [14:0] DEC   = 15'h0010;
    localparam logic [14:0] ADD   = 15'h0020;
    localparam logic [14:0] SUB   = 15'h0040;
    localparam logic [14:0] SHR   = 15'h0080;
    localparam logic [14:0] LDP   = 15'h0100;
    localparam logic [14:0] CLRP  = 15'h0200;
    localparam logic [14:0] SETV  = 15'h0400;
    localparam logic [14:0] CLRV  = 15'h0800;
    localparam logic [14:0] SETUP = LDY | LDQ | CLRA | LDCNT | CLRV;

    logic           clk;
    logic           reset;
    logic [14:0]    c;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           zq, zy, zr, valid;
    logic [2*N-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    robs_datapath #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .c            (c),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .zq           (zq),
        .zy           (zy),
        .zr           (zr),
        .product      (product),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a control word at the falling edge, return just after the rising edge
    task automatic step(input logic [14:0] cw);
        @(negedge clk);
        c = cw;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({zq, zy, zr, product, valid} !== {1'b0, 1'b1, 1'b1, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: zq=%b zy=%b zr=%b product=%h valid=%b, required 0 1 1 0000 0",
                     tag, zq, zy, zr, product, valid);
        end
    endtask

    // Canonical sequence; expected product supplied by caller
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_p, input string tag);
        int loops;
        multiplicand = a;
        multiplier   = b;
        step(SETUP);
        n_checks++;
        if ({zy, zq, zr, valid} !== {(a == 8'h00), b[0], 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s setup flags: zy zq zr valid=%b%b%b%b, required %b%b00",
                     tag, zy, zq, zr, valid, (a == 8'h00), b[0]);
        end
        loops = 0;
        while (!zr && loops < 20) begin
            step((zq ? ADD : 15'h0) | SHR | DEC);
            loops++;
        end
        n_checks++;
        if (loops != N - 1) begin
            n_fail++;
            $display("FAIL %s loop count: got %0d, required %0d", tag, loops, N - 1);
        end
        step((zq ? SUB : 15'h0) | SHR);
        step(LDP | SETV);
        n_checks++;
        if (product !== exp_p || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s product: got %h valid=%b, required %h valid=1",
                     tag, product, valid, exp_p);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        c = 15'h7fff;
        multiplicand = 8'h55;
        multiplier = 8'h33;
        #3;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_held_c_ignored");
        @(negedge clk);
        c = 15'h0;
        reset = 1'b1;
    endtask

    task automatic test_spec_vectors();
        run_mul(8'd5,   8'd3,   16'h000F, "5x3");
        run_mul(8'hFB,  8'd3,   16'hFFF1, "-5x3");
        run_mul(8'd5,   8'hFD,  16'hFFF1, "5x-3");
        run_mul(8'hFB,  8'hFD,  16'h000F, "-5x-3");
        run_mul(8'h80,  8'h80,  16'h4000, "-128x-128");
        run_mul(8'h7F,  8'h80,  16'hC080, "127x-128");
    endtask

    task automatic test_random_products();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] a, b;
            int ia, ib;
            a = 8'($urandom);
            b = 8'($urandom);
            ia = int'($signed(a));
            ib = int'($signed(b));
            run_mul(a, b, 16'(ia * ib), "random");
        end
    endtask

    task automatic test_counter_flags();
        multiplicand = 8'h00;
        multiplier   = 8'h01;
        step(SETUP);
        n_checks++;
        if ({zy, zq, zr} !== 3'b110) begin
            n_fail++;
            $display("FAIL counter_setup: zy zq zr=%b%b%b, required 110", zy, zq, zr);
        end
        for (int k = 1; k <= 8; k++) begin
            step(DEC);
            n_checks++;
            if (zr !== (k >= 7)) begin
                n_fail++;
                $display("FAIL counter_dec%0d: zr=%b, required %b", k, zr, (k >= 7));
            end
        end
        // LDCNT wins over DEC: reload to N-1, not N-2
        step(LDCNT | DEC);
        for (int k = 1; k <= 7; k++) begin
            step(DEC);
            n_checks++;
            if (zr !== (k == 7)) begin
                n_fail++;
                $display("FAIL ldcnt_over_dec%0d: zr=%b, required %b", k, zr, (k == 7));
            end
        end
    endtask

    task automatic test_conflicts();
        // Build A=0x12, Q=0x81
        multiplicand = 8'h12;
        multiplier   = 8'h81;
        step(LDY | LDQ | CLRA);
        step(ADD);
        step(LDP);
        n_checks++;
        if (product !== 16'h1281) begin
            n_fail++;
            $display("FAIL conflict_prep: product=%h, required 1281", product);
        end
        step(ADD | SUB);
        step(LDP);
        n_checks++;
        if (product !== 16'h1281) begin
            n_fail++;
            $display("FAIL add_sub_noop: product=%h, required 1281", product);
        end
        step(CLRA | ADD | SHR);
        step(LDP);
        n_checks++;
        if (product !== 16'h0040) begin
            n_fail++;
            $display("FAIL clra_add_shr: product=%h, required 0040", product);
        end
        // A further shift exposes F through A[7]
        step(SHR);
        step(LDP);
        n_checks++;
        if (product !== 16'h0020) begin
            n_fail++;
            $display("FAIL clra_f_zero: product=%h, required 0020", product);
        end
        step(LDP | CLRP);
        n_checks++;
        if (product !== 16'h0000) begin
            n_fail++;
            $display("FAIL ldp_clrp: product=%h, required 0000", product);
        end
        step(SETV);
        step(SETV | CLRV);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL setv_clrv: valid=%b, required 0", valid);
        end
        // LDQ beats SHR: shifting Q=01 would give zq=0
        multiplier = 8'h01;
        step(LDQ | CLRA);
        step(LDQ | SHR);
        n_checks++;
        if (zq !== 1'b1) begin
            n_fail++;
            $display("FAIL ldq_over_shr: zq=%b, required 1", zq);
        end
        // Sum uses pre-edge Y: Y=3 then ADD|LDY(100) adds 3
        multiplicand = 8'd3;
        multiplier   = 8'h00;
        step(LDY | LDQ | CLRA);
        multiplicand = 8'd100;
        step(ADD | LDY);
        step(LDP);
        n_checks++;
        if (product !== 16'h0300) begin
            n_fail++;
            $display("FAIL ldy_add_same_cycle: product=%h, required 0300", product);
        end
        step(ADD);
        step(LDP);
        n_checks++;
        if (product !== 16'h6700 || zy !== 1'b0) begin
            n_fail++;
            $display("FAIL ldy_took_effect: product=%h zy=%b, required 6700 0", product, zy);
        end
    endtask

    task automatic test_reset_mid_run();
        int loops;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom) | 8'h01;
        step(SETUP);
        for (loops = 0; loops < 3; loops++) begin
            step((zq ? ADD : 15'h0) | SHR | DEC);
        end
        @(negedge clk);
        c = (zq ? ADD : 15'h0) | SHR | DEC;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_run");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_run_held");
        @(negedge clk);
        c = 15'h0;
        reset = 1'b1;
        run_mul(8'd7, 8'd9, 16'h003F, "7x9_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a, b;
            a = (i == 0) ? 8'h80 : 8'($urandom);
            b = (i == 1) ? 8'h7F : 8'($urandom);
            run_mul(a, b, 16'(int'($signed(a)) * int'($signed(b))), "back_to_back");
        end
    endtask

    initial begin
        c = 15'h0;
        multiplicand = '0;
        multiplier = '0;
        test_reset();
        test_spec_vectors();
        test_counter_flags();
        test_conflicts();
        test_random_products();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
